mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch (IF) stage and the load/store (MEM) stage of the 5-stage RISC-V pipeline.
- Serialises requests with one outstanding access at a time and tolerates multi-cycle memory latency.
- Aborts on a wait timeout.
- Drives the IF and MEM stall signals consumed by the PC/IF_ID write-enable logic, alongside the hazard detection stalls.

Parameters:
XLEN, 32, data width
ADDR_W, 32, address width
MAX_WAIT, 15, max cycles mem_req may stay high without mem_ready before abort
WAIT_W, 4, wait counter width; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
ifu_req  input  1  fetch request; held until ifu_rvalid
ifu_addr  input  ADDR_W  fetch address; stable while ifu_req
ifu_rvalid  output  1  one-cycle fetch completion pulse
ifu_rdata  output  XLEN  fetched word, valid with ifu_rvalid
lsu_req  input  1  load/store request; held until lsu_rvalid
lsu_we  input  1  1 = store
lsu_addr  input  ADDR_W  data address
lsu_wdata  input  XLEN  store data
lsu_wstrb  input  XLEN/8  byte strobes
lsu_rvalid  output  1  one-cycle completion pulse, loads and stores
lsu_rdata  output  XLEN  load data; 0 for stores
bus_err  output  1  pulses with the rvalid of a timed-out access
if_stall  output  1  ifu_req && !ifu_rvalid
mem_stall  output  1  lsu_req && !lsu_rvalid
mem_req  output  1  memory access strobe
mem_we  output  1  write enable
mem_addr  output  ADDR_W  registered address
mem_wdata  output  XLEN  registered write data
mem_wstrb  output  XLEN/8  registered strobes; 0 on reads
mem_ready  input  1  memory completes access this cycle
mem_rdata  input  XLEN  read data, valid with mem_ready

Behaviour:
- Clocking and reset: single clock. Reset is asynchronous and active-high (rst).
- Reset values:
  - State = IDLE.
  - All outputs 0, including mem_addr, mem_wdata, rdata registers and the wait counter.
- States: IDLE, IF_BUSY, LS_BUSY.
- Arbitration, evaluated in IDLE and in the completion cycle of a busy state:
  - lsu_req wins over ifu_req, because the older instruction goes first.
  - A requester whose access is completing in the current cycle is excluded from that cycle's arbitration.
- Grant:
  - Registers the address, and for a store also we/wdata/wstrb, into the mem_* registers.
  - Moves to the matching BUSY state.
  - mem_req is 1 in BUSY states only. It is first high the cycle after the grant decision.
- Completion, when mem_ready=1 in a BUSY state:
  - The next cycle, the matching rvalid pulses for exactly 1 cycle.
  - rdata is registered from mem_rdata (lsu_rdata = 0 for stores).
  - State goes to the next grant, or to IDLE.
  - Back-to-back issue: the new mem_req follows the completion cycle with no idle gap.
- Minimum latency: request cycle N → mem_req at N+1; with mem_ready at N+1, rvalid at N+2.
- Wait counter:
  - Cleared on grant; increments each BUSY cycle with mem_ready=0.
  - When it reaches MAX_WAIT, the access is aborted: rvalid pulses, bus_err pulses with it, rdata = 0, and state returns to IDLE/regrant.
  - A late mem_ready arriving after the abort is ignored.
- mem_ready is ignored in IDLE.
- Stalls are combinational. if_stall=1 means PC write and IF_ID write are blocked. mem_stall=1 freezes EX/MEM/WB.
- Requester rule: a requester that drops req before its rvalid violates the protocol. The arbiter still completes the access but suppresses the rvalid.
- Reset mid-access: mem_req drops asynchronously, no rvalid is produced, and the access is lost.

Optional Feature:
ARB_RR_EN
- Defined: round-robin on simultaneous requests. A 1-bit last-winner register gives priority to the requester not served last. Reset value of last-winner = IF, so the LSU wins the first tie.
- Undefined: fixed LSU priority as above; no last-winner register.

Decomposition:
- Package arb_pkg holds:
  - the state enum (IDLE=2'd0, IF_BUSY=2'd1, LS_BUSY=2'd2);
  - requester ID constants REQ_IF=1'b0, REQ_LSU=1'b1;
  - opcode constants shared with the hazard logic (lw 7'b0000011, sw 7'b0100011).
- One sub-module, mem_wait_timer:
  - inputs clear and busy, plus mem_ready;
  - produces the timeout flag;
  - parameters MAX_WAIT and WAIT_W.

Test Plan:
1. ifu_req=1, addr 0x100, mem_ready high 1 cycle after mem_req → mem_req at N+1, ifu_rvalid at N+2 with rdata=mem_rdata, if_stall low at N+3.
2. ifu_req and lsu_req (load 0x2000) both asserted at N → LSU served first. IF mem_req starts the cycle after the LSU completion cycle. if_stall stays high throughout.
3. Store: lsu_we=1, wdata 0xDEADBEEF, wstrb 4'b0011, mem_ready after 3 wait cycles → mem_we=1, mem_wstrb=0011 held stable, lsu_rvalid pulse with lsu_rdata=0.
4. mem_ready never asserted → bus_err and rvalid pulse after MAX_WAIT=15 wait cycles. A later mem_ready in IDLE is ignored.
5. rst asserted while in LS_BUSY → mem_req=0 immediately, no rvalid. A fresh ifu_req after rst is released is served normally.
6. With ARB_RR_EN, both requests held continuously → grants alternate LSU, IF, LSU, IF. Without the macro → LSU every time.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
// Opcode constants are also consumed by the hazard logic.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    LS_BUSY = 2'd2
  } arb_state_e;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts busy cycles without mem_ready; flags the cycle an access
// has waited MAX_WAIT cycles so the arbiter can abort it.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  input  logic mem_ready,
  output logic timeout
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (busy && !mem_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The MAX_WAIT-th unanswered cycle is the abort cycle.
  assign timeout = busy && !mem_ready &&
                   (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF and MEM stages.
// Optional round-robin tie-break when ARB_RR_EN is defined.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rvalid,
  output logic [XLEN-1:0]   ifu_rdata,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [XLEN/8-1:0] lsu_wstrb,
  output logic              lsu_rvalid,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              bus_err,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);

  arb_state_e state_q, state_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic              ifu_rvalid_q, ifu_rvalid_d;
  logic              lsu_rvalid_q, lsu_rvalid_d;
  logic [XLEN-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [XLEN-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              drop_q, drop_d;

  logic busy, timeout, done;
  logic if_done, ls_done;
  logic if_elig, ls_elig;
  logic arb_en, lsu_first;
  logic gnt_if, gnt_ls;
  logic own_req, deliver;

  assign busy    = (state_q != IDLE);
  assign done    = busy && (mem_ready || timeout);
  assign if_done = done && (state_q == IF_BUSY);
  assign ls_done = done && (state_q == LS_BUSY);
  assign own_req = (state_q == LS_BUSY) ? lsu_req : ifu_req;
  assign deliver = own_req && !drop_q;

  // A requester in its rvalid cycle still holds req; keep it out.
  assign if_elig = ifu_req && !ifu_rvalid_q && !if_done;
  assign ls_elig = lsu_req && !lsu_rvalid_q && !ls_done;
  assign arb_en  = !busy || done;

`ifdef ARB_RR_EN
  logic last_q, last_d;

  assign lsu_first = (last_q == REQ_IF);

  always_comb begin
    last_d = last_q;
    if (gnt_ls) begin
      last_d = REQ_LSU;
    end else if (gnt_if) begin
      last_d = REQ_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_IF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign lsu_first = 1'b1;
`endif

  assign gnt_ls = arb_en && ls_elig && (lsu_first || !if_elig);
  assign gnt_if = arb_en && if_elig && !gnt_ls;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (gnt_ls || gnt_if),
    .busy      (busy),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    ifu_rvalid_d = 1'b0;
    lsu_rvalid_d = 1'b0;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    bus_err_d    = 1'b0;
    drop_d       = drop_q;
    if (busy && !own_req) begin
      drop_d = 1'b1;
    end
    if (done) begin
      state_d     = IDLE;
      mem_we_d    = 1'b0;
      mem_wstrb_d = '0;
      bus_err_d   = deliver && timeout;
      if (if_done) begin
        ifu_rvalid_d = deliver;
        ifu_rdata_d  = timeout ? '0 : mem_rdata;
      end else begin
        lsu_rvalid_d = deliver;
        lsu_rdata_d  = (timeout || mem_we_q) ? '0 : mem_rdata;
      end
    end
    if (gnt_ls) begin
      state_d     = LS_BUSY;
      mem_addr_d  = lsu_addr;
      mem_we_d    = lsu_we;
      mem_wstrb_d = lsu_we ? lsu_wstrb : '0;
      drop_d      = 1'b0;
      if (lsu_we) begin
        mem_wdata_d = lsu_wdata;
      end
    end else if (gnt_if) begin
      state_d     = IF_BUSY;
      mem_addr_d  = ifu_addr;
      mem_we_d    = 1'b0;
      mem_wstrb_d = '0;
      drop_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
      bus_err_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
      bus_err_q    <= bus_err_d;
      drop_q       <= drop_d;
    end
  end

  assign mem_req    = busy;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign ifu_rvalid = ifu_rvalid_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign ifu_rdata  = ifu_rdata_q;
  assign lsu_rdata  = lsu_rdata_q;
  assign bus_err    = bus_err_q;
  assign if_stall   = ifu_req && !ifu_rvalid_q;
  assign mem_stall  = lsu_req && !lsu_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random rounds, memory
// responder with random latency, directed reset/drop cases.
module tb_mem_port_arbiter;

  localparam int MAXW = 15;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
  } acc_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wstrb = '0;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        bus_err;
  logic        if_stall;
  logic        mem_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;
  bit last_lsu = 1'b0;

  acc_t  mem_q[$];
  resp_t if_q[$];
  resp_t ls_q[$];

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req    (ifu_req),
    .ifu_addr   (ifu_addr),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rdata  (ifu_rdata),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_wstrb  (lsu_wstrb),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .bus_err    (bus_err),
    .if_stall   (if_stall),
    .mem_stall  (mem_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_1234;
  endfunction

  // Completion: ready after lat waits, or abort on the MAXW-th wait.
  function automatic resp_t mk_resp(input acc_t a, input int unsigned start);
    resp_t r;
    r.err   = (a.lat >= MAXW);
    r.cyc   = start + (r.err ? MAXW - 1 : a.lat) + 1;
    r.rdata = (r.err || a.we) ? 32'h0 : rd_fn(a.addr);
    return r;
  endfunction

  function automatic int rand_lat();
    return ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(0, 3);
  endfunction

  // Memory responder: checks each access against the expected order.
  initial begin
    acc_t cur;
    bit   active = 1'b0;
    int   idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        active    = 1'b0;
        mem_ready = 1'b0;
      end else begin
        if (!active && mem_req) begin
          if (mem_q.size() == 0) begin
            chk("unexpected_access", {31'b0, mem_req}, 64'h0);
          end else begin
            cur    = mem_q.pop_front();
            active = 1'b1;
            idx    = 0;
          end
        end
        if (active) begin
          chk("mem_req_held", {63'b0, mem_req}, 64'h1);
          chk("mem_addr", {32'b0, mem_addr}, {32'b0, cur.addr});
          chk("mem_we_strb", {59'b0, mem_we, mem_wstrb},
              {59'b0, cur.we, cur.we ? cur.wstrb : 4'h0});
          if (cur.we) chk("mem_wdata", {32'b0, mem_wdata}, {32'b0, cur.wdata});
          if (cur.lat < MAXW && idx == cur.lat) begin
            mem_ready = 1'b1;
            mem_rdata = rd_fn(cur.addr);
            active    = 1'b0;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom();
            if (idx == MAXW - 1) active = 1'b0;
            idx++;
          end
        end else if (!mem_req) begin
          mem_ready = ($urandom_range(0, 3) == 0);
          mem_rdata = $urandom();
        end else begin
          mem_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected responses whenever an rvalid appears.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("if_stall", {63'b0, if_stall}, {63'b0, ifu_req && !ifu_rvalid});
        chk("mem_stall", {63'b0, mem_stall}, {63'b0, lsu_req && !lsu_rvalid});
        if (!ifu_rvalid && !lsu_rvalid) chk("bus_err_idle", {63'b0, bus_err}, 64'h0);
        if (ifu_rvalid) begin
          if (if_q.size() == 0) begin
            chk("spurious_ifu_rvalid", 64'h1, 64'h0);
          end else begin
            r = if_q.pop_front();
            chk("ifu_cycle", {32'b0, cyc}, {32'b0, r.cyc});
            chk("ifu_rdata", {32'b0, ifu_rdata}, {32'b0, r.rdata});
            chk("ifu_bus_err", {63'b0, bus_err}, {63'b0, r.err});
          end
        end
        if (lsu_rvalid) begin
          if (ls_q.size() == 0) begin
            chk("spurious_lsu_rvalid", 64'h1, 64'h0);
          end else begin
            r = ls_q.pop_front();
            chk("lsu_cycle", {32'b0, cyc}, {32'b0, r.cyc});
            chk("lsu_rdata", {32'b0, lsu_rdata}, {32'b0, r.rdata});
            chk("lsu_bus_err", {63'b0, bus_err}, {63'b0, r.err});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = IF only, 1 = LSU only, 2 = both in the same cycle.
  task automatic do_round(input int kind, input acc_t fa, input acc_t la);
    resp_t fr, lr;
    bit    lsu_first;
    int unsigned k;
    k = cyc;
`ifdef ARB_RR_EN
    lsu_first = !last_lsu;
`else
    lsu_first = 1'b1;
`endif
    fa.we = 1'b0;
    if (kind == 0) begin
      mem_q.push_back(fa);
      if_q.push_back(mk_resp(fa, k + 1));
      last_lsu = 1'b0;
    end else if (kind == 1) begin
      mem_q.push_back(la);
      ls_q.push_back(mk_resp(la, k + 1));
      last_lsu = 1'b1;
    end else if (lsu_first) begin
      mem_q.push_back(la);
      mem_q.push_back(fa);
      lr = mk_resp(la, k + 1);
      fr = mk_resp(fa, lr.cyc);
      ls_q.push_back(lr);
      if_q.push_back(fr);
      last_lsu = 1'b0;
    end else begin
      mem_q.push_back(fa);
      mem_q.push_back(la);
      fr = mk_resp(fa, k + 1);
      lr = mk_resp(la, fr.cyc);
      if_q.push_back(fr);
      ls_q.push_back(lr);
      last_lsu = 1'b1;
    end
    ifu_req   = (kind != 1);
    ifu_addr  = fa.addr;
    lsu_req   = (kind != 0);
    lsu_we    = la.we;
    lsu_addr  = la.addr;
    lsu_wdata = la.wdata;
    lsu_wstrb = la.wstrb;
    for (int i = 0; i < 80 && (ifu_req || lsu_req); i++) begin
      tick();
      if (ifu_req && ifu_rvalid) ifu_req = 1'b0;
      if (lsu_req && lsu_rvalid) lsu_req = 1'b0;
    end
    if (ifu_req || lsu_req) begin
      chk("round_timeout", {62'b0, ifu_req, lsu_req}, 64'h0);
      ifu_req = 1'b0;
      lsu_req = 1'b0;
    end
    repeat (1 + $urandom_range(0, 2)) tick();
  endtask

  function automatic acc_t rand_if();
    acc_t a;
    a.addr  = $urandom() & 32'hFFFF_FFFC;
    a.we    = 1'b0;
    a.wdata = '0;
    a.wstrb = '0;
    a.lat   = rand_lat();
    return a;
  endfunction

  function automatic acc_t rand_ls();
    acc_t a;
    a.addr  = $urandom() & 32'hFFFF_FFFC;
    a.we    = 1'($urandom_range(0, 1));
    a.wdata = $urandom();
    a.wstrb = 4'($urandom_range(1, 15));
    a.lat   = rand_lat();
    return a;
  endfunction

  initial begin
    acc_t fa, la;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_mem", {mem_req, mem_we, mem_wstrb, mem_addr}, 64'h0);
    chk("reset_wdata", {32'b0, mem_wdata}, 64'h0);
    chk("reset_rvalid", {61'b0, ifu_rvalid, lsu_rvalid, bus_err}, 64'h0);
    chk("reset_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
    chk("reset_stall", {62'b0, if_stall, mem_stall}, 64'h0);
    tick();

    fa = rand_if(); la = rand_ls();
    fa.addr = 32'h100; fa.lat = 0;
    do_round(0, fa, la);

    fa = rand_if(); la = rand_ls();
    la.addr = 32'h2000; la.we = 1'b0; la.lat = 1; fa.lat = 0;
    do_round(2, fa, la);

    la.addr = 32'h3000; la.we = 1'b1; la.wdata = 32'hDEADBEEF;
    la.wstrb = 4'b0011; la.lat = 3;
    do_round(1, fa, la);

    fa.addr = 32'h400; fa.lat = MAXW;
    do_round(0, fa, la);

    for (int n = 0; n < 60; n++) begin
      do_round($urandom_range(0, 2), rand_if(), rand_ls());
    end

    // Requester abandons its fetch: access completes, rvalid suppressed.
    fa = rand_if(); fa.lat = 5;
    mem_q.push_back(fa);
    ifu_addr = fa.addr;
    ifu_req  = 1'b1;
    last_lsu = 1'b0;
    repeat (2) tick();
    ifu_req = 1'b0;
    repeat (10) tick();

    // Reset in the middle of a load: access is lost.
    la = rand_ls(); la.we = 1'b0; la.lat = 10;
    mem_q.push_back(la);
    lsu_we   = 1'b0;
    lsu_addr = la.addr;
    lsu_req  = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mem_req", {63'b0, mem_req}, 64'h0);
    chk("rst_rvalid", {62'b0, ifu_rvalid, lsu_rvalid}, 64'h0);
    lsu_req  = 1'b0;
    last_lsu = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    fa = rand_if(); fa.lat = 1;
    do_round(0, fa, la);
    fa = rand_if(); la = rand_ls();
    do_round(2, fa, la);

    repeat (4) tick();
    chk("queues_drained", {32'(mem_q.size()), 16'(if_q.size()), 16'(ls_q.size())}, 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
